ppa_accum: RTL and testbench
============================

// Module: ppa_accum
// PURPOSE
//   Sequential accumulator wrapped around the 16-bit Sklansky prefix adder (ppa).
//   Sums a burst of LEN 16-bit operands into a 16-bit result with a sticky overflow flag.
//   Acts as the stage directly upstream and downstream of ppa: drives its A/B inputs from
//   the accumulator and input port, and registers its S/CO outputs.
//   Streaming valid/ready on input and output.
// PARAMETERS
//   WIDTH  16  datapath width; fixed to ppa width, any other value is illegal
//   CNT_W  8   width of burst length and beat counter
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      begin a burst; sampled only in IDLE
//   len        in   CNT_W  operand count for the burst; sampled with start
//   in_valid   in   1      operand beat valid
//   in_ready   out  1      accumulator accepts a beat
//   in_data    in   WIDTH  operand
//   out_valid  out  1      result held valid
//   out_ready  in   1      downstream consumes result
//   out_sum    out  WIDTH  accumulated sum modulo 2^WIDTH
//   out_ovf    out  1      OR of ppa CO over all beats of the burst
//   busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//   Reset: clk and rst are fixed; rst is synchronous, active-high, on one clock.
//     rst -> state IDLE, acc=0, ovf=0, cnt=0.
//     All outputs go low/zero the cycle after rst is sampled.
//     rst mid-burst aborts the burst; no partial result is presented.
//   Datapath: ppa.A=acc, ppa.B=in_data, combinational. Beat accept = in_valid & in_ready.
//   FSM states:
//   - IDLE: in_ready=0, out_valid=0.
//     start & len!=0 -> ACC; acc<=0, ovf<=0, cnt<=len.
//     start & len==0 -> DONE; acc<=0, ovf<=0.
//   - ACC: in_ready=1. On accept: acc<=ppa.S, ovf<=ovf|ppa.CO, cnt<=cnt-1.
//     Accept while cnt==1 -> DONE. in_valid low -> hold all state.
//   - DONE: out_valid=1, out_sum=acc, out_ovf=ovf, in_ready=0.
//     out_ready -> IDLE. Otherwise hold, with outputs stable.
//   Latency: result is valid the cycle after the last beat is accepted.
//     With continuous in_valid, throughput is one beat per cycle.
//   out_sum and out_ovf are driven from registers in every state. They are meaningful
//     only while out_valid=1.
//   start outside IDLE is ignored. So is start in the cycle where DONE exits to IDLE;
//     the next burst needs start in IDLE.
//   Counter underflow cannot occur: ACC is entered only with cnt>=1.
//   len=2^CNT_W-1 is the maximum burst length.
//   in_data is ignored unless the beat is accepted.
// STRUCTURE
//   Shared package ppa_pkg:
//   - PPA_WIDTH=16 localparam.
//   - acc_state_t enum {IDLE, ACC, DONE}, 2-bit encoding.
//   One sub-module: existing ppa (u_ppa), instantiated unchanged.
//   No other sub-modules. FSM, counter and registers are inline.
// TESTING
//   1 Reset: assert rst 2 cycles mid-ACC -> next cycle IDLE.
//     in_ready=0, out_valid=0, busy=0, out_sum=0.
//   2 Basic: start, len=3; beats 0x0001, 0x0002, 0x0003 back-to-back.
//     -> out_valid the cycle after beat 3, out_sum=0x0006, out_ovf=0.
//   3 Overflow: len=2; beats 0xFFFF, 0x0002 -> out_sum=0x0001, out_ovf=1.
//     Sticky: len=3, beats 0xFFFF, 0x0001, 0x0001 -> out_sum=0x0001, out_ovf=1.
//   4 Backpressure: len=2, in_valid gaps of 3 cycles between beats, out_ready low 5 cycles.
//     -> acc holds through the gaps; out_sum=0x0A0A from 0x0505+0x0505, stable until
//     out_ready.
//   5 Zero length / ignored start: start with len=0 -> DONE next cycle, out_sum=0, out_ovf=0.
//     start pulsed during ACC -> no effect on cnt or acc.
//   6 Max burst: len=255 of 0x0101 -> out_sum=0xFFFF, out_ovf=0.
//     Random sweep against a reference model: sum mod 2^16, ovf = any carry-out.

Source files
------------

// File: rtl/ppa_pkg.sv
// Shared definitions for the Sklansky prefix adder and its burst accumulator.
package ppa_pkg;

   localparam int unsigned PPA_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } acc_state_t;

endpackage

// File: rtl/ppa.sv
// 16-bit Sklansky parallel-prefix adder: purely combinational, no carry-in.
module ppa
   import ppa_pkg::*;
(
   input  logic [PPA_WIDTH-1:0] a,
   input  logic [PPA_WIDTH-1:0] b,
   output logic [PPA_WIDTH-1:0] s,
   output logic                 co
);

   localparam int unsigned LEVELS = 4;

   // Each level merges a bit's group with the top bit of the adjacent lower block of size 2^l.
   function automatic logic [PPA_WIDTH:0] sklansky_add(input logic [PPA_WIDTH-1:0] x,
                                                       input logic [PPA_WIDTH-1:0] y);
      logic [PPA_WIDTH-1:0] g;
      logic [PPA_WIDTH-1:0] p;
      logic [PPA_WIDTH-1:0] p0;
      logic [PPA_WIDTH-1:0] g_n;
      logic [PPA_WIDTH-1:0] p_n;
      int                   j;
      g  = x & y;
      p  = x ^ y;
      p0 = p;
      for (int l = 0; l < int'(LEVELS); l++) begin
         g_n = g;
         p_n = p;
         for (int i = 0; i < int'(PPA_WIDTH); i++) begin
            if (((i >> l) & 1) == 1) begin
               j      = ((i >> l) << l) - 1;
               g_n[i] = g[i] | (p[i] & g[j]);
               p_n[i] = p[i] & p[j];
            end
         end
         g = g_n;
         p = p_n;
      end
      return {g[PPA_WIDTH-1], p0 ^ {g[PPA_WIDTH-2:0], 1'b0}};
   endfunction

   always_comb begin
      {co, s} = sklansky_add(a, b);
   end

endmodule

// File: rtl/ppa_accum.sv
// Burst accumulator around the ppa adder: sums LEN operands with a sticky carry-out flag.
module ppa_accum
   import ppa_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_ovf,
   output logic             busy
);

   if (WIDTH != PPA_WIDTH) begin : g_bad_width
      $error("ppa_accum: WIDTH must equal the ppa width");
   end

   acc_state_t       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic [WIDTH-1:0] ppa_s;
   logic             ppa_co;

   ppa u_ppa (
      .a  (acc_q),
      .b  (in_data),
      .s  (ppa_s),
      .co (ppa_co)
   );

   // Next state; handshake flags are registered copies of the next-state decode.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d = '0;
               ovf_d = 1'b0;
               if (len != '0) begin
                  cnt_d   = len;
                  state_d = ACC;
               end else begin
                  state_d = DONE;
               end
            end
         end
         ACC: begin
            if (in_valid) begin
               acc_d = ppa_s;
               ovf_d = ovf_q | ppa_co;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == ACC);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_ppa_accum.sv
// Self-checking bench for ppa_accum: burst model pushes expected {ovf,sum}, popped at result.
module tb_ppa_accum;

   localparam int unsigned W  = 16;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] len = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_sum;
   logic          out_ovf;
   logic          busy;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [W:0]    exp_q[$];
   logic [W-1:0]  beats[256];
   logic [W:0]    e;

   ppa_accum #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   // Starts a burst in IDLE, feeds beats[0..n-1] with 'gap' idle cycles between beats.
   task automatic drive_burst(input int n, input int gap);
      logic [W:0]   t;
      logic [W-1:0] s;
      logic         o;
      s = '0;
      o = 1'b0;
      start = 1'b1;
      len   = CW'(n);
      step();
      start = 1'b0;
      len   = CW'($urandom);
      for (int i = 0; i < n; i++) begin
         t = {1'b0, s} + {1'b0, beats[i]};
         s = t[W-1:0];
         o = o | t[W];
         in_valid = 1'b1;
         in_data  = beats[i];
         step();
         in_valid = 1'b0;
         in_data  = W'($urandom);
         if (i < n - 1) repeat (gap) step();
      end
      exp_q.push_back({o, s});
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, busy, out_sum} !== '0) begin
         n_fail++;
         $display("FAIL reset_initial: got rdy=%b vld=%b busy=%b sum=%h expected all zero",
                  in_ready, out_valid, busy, out_sum);
      end
      start = 1'b1;
      len   = 8'd5;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h1234;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || out_sum !== 16'h1234) begin
         n_fail++;
         $display("FAIL reset_midburst: got busy=%b rdy=%b sum=%h expected 1 1 1234",
                  busy, in_ready, out_sum);
      end
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, busy, out_sum, out_ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_abort: got rdy=%b vld=%b busy=%b sum=%h ovf=%b expected all zero",
                  in_ready, out_valid, busy, out_sum, out_ovf);
      end
      in_valid = 1'b1;
      in_data  = 16'h0042;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_idle_ignores_beat: got rdy=%b vld=%b sum=%h expected 0 0 0000",
                  in_ready, out_valid, out_sum);
      end
   endtask

   task automatic test_basic();
      beats[0] = 16'h0001;
      beats[1] = 16'h0002;
      beats[2] = 16'h0003;
      drive_burst(3, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== e[W-1:0] || out_ovf !== e[W]) begin
         n_fail++;
         $display("FAIL basic_result: got vld=%b sum=%h ovf=%b expected 1 %h %b",
                  out_valid, out_sum, out_ovf, e[W-1:0], e[W]);
      end
      consume();
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_release: got vld=%b busy=%b expected 0 0", out_valid, busy);
      end
   endtask

   task automatic test_overflow();
      beats[0] = 16'hFFFF;
      beats[1] = 16'h0002;
      drive_burst(2, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== e[W-1:0] || out_ovf !== e[W]) begin
         n_fail++;
         $display("FAIL overflow_result: got vld=%b sum=%h ovf=%b expected 1 %h %b",
                  out_valid, out_sum, out_ovf, e[W-1:0], e[W]);
      end
      consume();
      beats[0] = 16'hFFFF;
      beats[1] = 16'h0001;
      beats[2] = 16'h0001;
      drive_burst(3, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== e[W-1:0] || out_ovf !== e[W]) begin
         n_fail++;
         $display("FAIL overflow_sticky: got vld=%b sum=%h ovf=%b expected 1 %h %b",
                  out_valid, out_sum, out_ovf, e[W-1:0], e[W]);
      end
      consume();
   endtask

   task automatic test_backpressure();
      start = 1'b1;
      len   = 8'd2;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h0505;
      step();
      in_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
         in_data = W'($urandom);
         step();
         n_checks++;
         if (out_sum !== 16'h0505 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_gap%0d: got sum=%h rdy=%b vld=%b expected 0505 1 0",
                     g, out_sum, in_ready, out_valid);
         end
      end
      in_valid = 1'b1;
      in_data  = 16'h0505;
      step();
      in_valid = 1'b0;
      exp_q.push_back({1'b0, 16'h0A0A});
      e = exp_q.pop_front();
      for (int h = 0; h < 5; h++) begin
         n_checks++;
         if (out_valid !== 1'b1 || out_sum !== e[W-1:0] || out_ovf !== e[W]) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got vld=%b sum=%h ovf=%b expected 1 %h %b",
                     h, out_valid, out_sum, out_ovf, e[W-1:0], e[W]);
         end
         step();
      end
      consume();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got vld=%b expected 0", out_valid);
      end
   endtask

   task automatic test_zero_len();
      start = 1'b1;
      len   = 8'd0;
      step();
      start = 1'b0;
      exp_q.push_back('0);
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== e[W-1:0] || out_ovf !== e[W] || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_len: got vld=%b sum=%h ovf=%b rdy=%b expected 1 %h %b 0",
                  out_valid, out_sum, out_ovf, in_ready, e[W-1:0], e[W]);
      end
      start     = 1'b1;
      len       = 8'd3;
      out_ready = 1'b1;
      step();
      start     = 1'b0;
      out_ready = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL start_on_exit: got busy=%b rdy=%b expected 0 0", busy, in_ready);
      end
      start = 1'b1;
      len   = 8'd3;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h0001;
      step();
      in_valid = 1'b0;
      start = 1'b1;
      len   = 8'd1;
      step();
      start = 1'b0;
      n_checks++;
      if (out_sum !== 16'h0001 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start_in_acc: got sum=%h rdy=%b expected 0001 1", out_sum, in_ready);
      end
      in_valid = 1'b1;
      in_data  = 16'h0002;
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_acc_cnt: got vld=%b after 2 of 3 beats expected 0", out_valid);
      end
      in_data = 16'h0003;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'h0006 || out_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_acc_sum: got vld=%b sum=%h ovf=%b expected 1 0006 0",
                  out_valid, out_sum, out_ovf);
      end
      consume();
   endtask

   task automatic test_max_burst();
      for (int i = 0; i < 255; i++) beats[i] = 16'h0101;
      drive_burst(255, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || out_sum !== 16'hFFFF || out_ovf !== 1'b0 || e !== {1'b0, out_sum}) begin
         n_fail++;
         $display("FAIL max_burst: got vld=%b sum=%h ovf=%b expected 1 FFFF 0 (model %h)",
                  out_valid, out_sum, out_ovf, e);
      end
      consume();
   endtask

   task automatic test_random();
      int n;
      for (int b = 0; b < 25; b++) begin
         n = int'($urandom_range(1, 20));
         for (int i = 0; i < n; i++) begin
            beats[i] = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(0, 255));
         end
         drive_burst(n, int'($urandom_range(0, 2)));
         repeat ($urandom_range(0, 2)) step();
         e = exp_q.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || out_sum !== e[W-1:0] || out_ovf !== e[W]) begin
            n_fail++;
            $display("FAIL random_burst%0d: got vld=%b sum=%h ovf=%b expected 1 %h %b",
                     b, out_valid, out_sum, out_ovf, e[W-1:0], e[W]);
         end
         consume();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_zero_len();
      test_max_burst();
      test_random();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
